seq_divider: RTL

- Iterative radix-2 restoring divider. Inverse companion to the single-cycle add/sub ALU: it consumes operands and produces quotient/remainder with the same z/v/n flag convention.
- Sits beside the ALU in the execute stage and serves DIV/DIVU.
- Quotient and remainder feed the LO/HI registers. Start/busy/done handshake; the pipeline stalls on busy.

---
 rtl/seq_divider.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for DIV/DIVU.
// Produces quotient/remainder with z/v/n flags. One quotient bit per cycle.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (signed DIV support).
// Without the macro, op is ignored, every divide is unsigned and n stays 0.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             z,
   output logic             v,
   output logic             n
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   state_t           nextstate;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] prem;
   logic             negq;
   logic             nega;
   logic             opl;

   logic             opeff;
   logic             bzero;
   logic             ovf;
   logic             fast;
   logic [WIDTH-1:0] absa;
   logic [WIDTH-1:0] absb;
   logic [WIDTH:0]   shifted;
   logic             qbit;
   logic [WIDTH-1:0] qfix;
   logic [WIDTH-1:0] rfix;

   // Decode the incoming request: effective signedness, operand magnitudes and fast-path cases
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      opeff = op;
      ovf   = op && (A == MINNEG) && (&B);
`else
      opeff = op & 1'b0;
      ovf   = 1'b0;
`endif
      bzero = (B == '0);
      fast  = bzero || ovf;
      absa  = (opeff && A[WIDTH-1]) ? (~A + 1'b1) : A;
      absb  = (opeff && B[WIDTH-1]) ? (~B + 1'b1) : B;
   end

   // One restoring step: shift in the next dividend bit and subtract the divisor if it fits
   always_comb begin
      shifted = {prem, dvd[WIDTH-1]};
      qbit    = (shifted >= {1'b0, dvs});
   end

   // Sign correction applied on the way out of FIX; remainder follows the dividend sign
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      qfix = negq ? (~dvd + 1'b1) : dvd;
      rfix = nega ? (~prem + 1'b1) : prem;
`else
      qfix = dvd;
      rfix = prem;
`endif
   end

   // Next-state logic and handshake outputs decoded from the current state
   always_comb begin
      nextstate = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) nextstate = fast ? DONE : CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == '0) nextstate = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            nextstate = DONE;
         end
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) nextstate = fast ? DONE : CALC;
            else       nextstate = IDLE;
         end
         default: nextstate = IDLE;
      endcase
   end

   // State register plus datapath: operand capture, iteration, and result/flag update on entry to DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         prem  <= '0;
         negq  <= 1'b0;
         nega  <= 1'b0;
         opl   <= 1'b0;
         quot  <= '0;
         rem   <= '0;
         z     <= 1'b0;
         v     <= 1'b0;
         n     <= 1'b0;
      end else begin
         state <= nextstate;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (bzero) begin
                     quot <= '1;
                     rem  <= A;
                     z    <= 1'b0;
                     v    <= 1'b1;
                     n    <= opeff;
                  end else if (ovf) begin
                     quot <= A;
                     rem  <= '0;
                     z    <= 1'b0;
                     v    <= 1'b1;
                     n    <= 1'b1;
                  end else begin
                     dvd  <= absa;
                     dvs  <= absb;
                     prem <= '0;
                     cnt  <= CNT_W'(WIDTH - 1);
                     negq <= opeff & (A[WIDTH-1] ^ B[WIDTH-1]);
                     nega <= opeff & A[WIDTH-1];
                     opl  <= opeff;
                  end
               end
            end
            CALC: begin
               dvd  <= {dvd[WIDTH-2:0], qbit};
               prem <= qbit ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            FIX: begin
               quot <= qfix;
               rem  <= rfix;
               z    <= (qfix == '0);
               v    <= 1'b0;
               n    <= opl & qfix[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

endmodule
